// File: rtl/voice_allocator_if.sv
// Key-input and voice-output bundle of the polyphonic voice allocator.
// The allocator sits on the slave side; the key source / voice consumer on the master side.
interface voice_allocator_if #(
    parameter int unsigned KEYS   = 8,
    parameter int unsigned VOICES = 4
);
    localparam int unsigned KW = $clog2(KEYS);

    logic [KEYS-1:0]        sw;
    logic [VOICES-1:0]      voice_act_o;
    logic [VOICES*KW-1:0]   voice_key_o;
    logic [VOICES-1:0]      voice_trig_o;
    logic                   steal_o;
    logic                   busy_o;

    modport master (
        output sw,
        input  voice_act_o,
        input  voice_key_o,
        input  voice_trig_o,
        input  steal_o,
        input  busy_o
    );

    modport slave (
        input  sw,
        output voice_act_o,
        output voice_key_o,
        output voice_trig_o,
        output steal_o,
        output busy_o
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: synchronises raw keys, serialises press/release events
// lowest-key-first, and maps them onto voice slots with oldest-voice stealing.
module voice_allocator #(
    parameter int unsigned KEYS   = 8,
    parameter int unsigned VOICES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    voice_allocator_if.slave bus
);
    localparam int unsigned KW = $clog2(KEYS);
    localparam int unsigned AW = $clog2(VOICES);

    // Reset age ordering: voice v has age v, so the highest voice is stolen first.
    function automatic logic [VOICES*AW-1:0] age_init();
        logic [VOICES*AW-1:0] a;
        a = '0;
        for (int v = 0; v < int'(VOICES); v++) a[v*AW +: AW] = AW'(v);
        return a;
    endfunction

    localparam logic [VOICES*AW-1:0] AGE_INIT = age_init();

    logic [KEYS-1:0]      sync_q, s_q, key_r_q, key_r_n;
    logic [VOICES-1:0]    act_q, act_n, trig_q, trig_n;
    logic [VOICES*KW-1:0] key_q, key_n;
    logic [VOICES*AW-1:0] age_q, age_n;
    logic                 steal_q, steal_n, busy_q;

    logic [KEYS-1:0]      pending;
    logic                 ev_valid;
    logic [KW-1:0]        ev_key;
    logic                 free_any;
    logic [AW-1:0]        free_idx, oldest_idx, alloc_idx, alloc_age;
    logic [VOICES-1:0]    match_vec;

    // Event selection: lowest pending key, and the voice that would receive it.
    always_comb begin
        pending    = s_q ^ key_r_q;
        ev_valid   = 1'b0;
        ev_key     = '0;
        free_any   = 1'b0;
        free_idx   = '0;
        oldest_idx = '0;
        alloc_age  = '0;
        match_vec  = '0;
        for (int i = 0; i < int'(KEYS); i++) begin
            if (pending[i] && !ev_valid) begin
                ev_valid = 1'b1;
                ev_key   = KW'(i);
            end
        end
        for (int v = 0; v < int'(VOICES); v++) begin
            if (!act_q[v] && !free_any) begin
                free_any = 1'b1;
                free_idx = AW'(v);
            end
            if (age_q[v*AW +: AW] == AW'(VOICES - 1)) oldest_idx = AW'(v);
            match_vec[v] = act_q[v] && (key_q[v*KW +: KW] == ev_key);
        end
        alloc_idx = free_any ? free_idx : oldest_idx;
        for (int v = 0; v < int'(VOICES); v++) begin
            if (AW'(v) == alloc_idx) alloc_age = age_q[v*AW +: AW];
        end
    end

    // Next voice state for the one event handled this cycle.
    always_comb begin
        key_r_n = key_r_q;
        act_n   = act_q;
        key_n   = key_q;
        age_n   = age_q;
        trig_n  = '0;
        steal_n = 1'b0;
        if (ev_valid) begin
            key_r_n[ev_key] = s_q[ev_key];
            if (s_q[ev_key]) begin
                steal_n = !free_any;
                for (int v = 0; v < int'(VOICES); v++) begin
                    if (AW'(v) == alloc_idx) begin
                        act_n[v]           = 1'b1;
                        key_n[v*KW +: KW]  = ev_key;
                        trig_n[v]          = 1'b1;
                        age_n[v*AW +: AW]  = '0;
                    end else if (age_q[v*AW +: AW] < alloc_age) begin
                        age_n[v*AW +: AW]  = age_q[v*AW +: AW] + AW'(1);
                    end
                end
            end else begin
                // A stolen note finds no match and leaves the voices untouched.
                act_n = act_q & ~match_vec;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            s_q     <= '0;
            key_r_q <= '0;
            act_q   <= '0;
            key_q   <= '0;
            age_q   <= AGE_INIT;
            trig_q  <= '0;
            steal_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= bus.sw;
            s_q     <= sync_q;
            key_r_q <= key_r_n;
            act_q   <= act_n;
            key_q   <= key_n;
            age_q   <= age_n;
            trig_q  <= trig_n;
            steal_q <= steal_n;
            busy_q  <= |pending;
        end
    end

    assign bus.voice_act_o  = act_q;
    assign bus.voice_key_o  = key_q;
    assign bus.voice_trig_o = trig_q;
    assign bus.steal_o      = steal_q;
    assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: expected allocations are queued when keys are
// driven and checked against every voice_trig_o pulse.
module tb_voice_allocator;
    localparam int unsigned KEYS   = 8;
    localparam int unsigned VOICES = 4;
    localparam int unsigned KW     = 3;

    typedef struct {
        int   voice;
        int   key;
        logic steal;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    voice_allocator_if #(.KEYS(KEYS), .VOICES(VOICES)) bus ();

    voice_allocator #(.KEYS(KEYS), .VOICES(VOICES)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ev_t exp_q[$];
    int  checks    = 0;
    int  errors    = 0;
    int  busy_cnt  = 0;
    int  steal_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int v, input int k, input logic s);
        ev_t e;
        e.voice = v;
        e.key   = k;
        e.steal = s;
        exp_q.push_back(e);
    endtask

    // One clock; any trigger pulse is matched against the oldest queued allocation.
    task automatic tick();
        ev_t e;
        @(negedge clk);
        if (bus.busy_o)  busy_cnt++;
        if (bus.steal_o) steal_cnt++;
        if (bus.voice_trig_o != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_trig", 32'(bus.voice_trig_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("trig_vec", 32'(bus.voice_trig_o), 32'd1 << e.voice);
                check("trig_key", 32'(bus.voice_key_o[e.voice*KW +: KW]), 32'(e.key));
                check("trig_steal", 32'(bus.steal_o), 32'(e.steal));
            end
        end else begin
            check("steal_without_trig", 32'(bus.steal_o), 32'd0);
        end
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain(input string tag);
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_act"},   32'(bus.voice_act_o),  32'd0);
        check({tag, "_key"},   32'(bus.voice_key_o),  32'd0);
        check({tag, "_trig"},  32'(bus.voice_trig_o), 32'd0);
        check({tag, "_steal"}, 32'(bus.steal_o),      32'd0);
        check({tag, "_busy"},  32'(bus.busy_o),       32'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.sw = '0;
        #1 rst = 1'b1;
        #1 check_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single press of key 2: exact latency and one-cycle pulses.
        busy_cnt = 0;
        push(0, 2, 1'b0);
        bus.sw = 8'h04;
        tick();
        tick();
        check("latency_act", 32'(bus.voice_act_o), 32'd0);
        check("latency_trig", 32'(bus.voice_trig_o), 32'd0);
        tick();
        check("press_act", 32'(bus.voice_act_o), 32'h1);
        check("press_busy", 32'(bus.busy_o), 32'd1);
        tick();
        check("pulse_end_trig", 32'(bus.voice_trig_o), 32'd0);
        check("pulse_end_busy", 32'(bus.busy_o), 32'd0);
        check("held_act", 32'(bus.voice_act_o), 32'h1);
        settle(3);
        check("single_busy_cycles", 32'(busy_cnt), 32'd1);
        drain("single_drain");
        bus.sw = 8'h00;
        settle(5);
        check("release_act", 32'(bus.voice_act_o), 32'd0);

        // Four simultaneous presses served in ascending key order.
        busy_cnt = 0;
        push(0, 0, 1'b0);
        push(1, 1, 1'b0);
        push(2, 2, 1'b0);
        push(3, 3, 1'b0);
        bus.sw = 8'h0F;
        settle(9);
        check("burst_act", 32'(bus.voice_act_o), 32'hF);
        check("burst_keys", 32'(bus.voice_key_o), 32'h688);
        check("burst_busy_cycles", 32'(busy_cnt), 32'd4);
        drain("burst_drain");

        // Steal the oldest voice; release of the stolen key is silent.
        push(0, 5, 1'b1);
        bus.sw = 8'h2F;
        settle(6);
        check("steal_act", 32'(bus.voice_act_o), 32'hF);
        check("steal_keys", 32'(bus.voice_key_o), 32'h68D);
        drain("steal_drain");
        bus.sw = 8'h2E;
        settle(6);
        check("stolen_release_act", 32'(bus.voice_act_o), 32'hF);
        check("stolen_release_keys", 32'(bus.voice_key_o), 32'h68D);
        bus.sw = 8'h0E;
        settle(6);
        check("thief_release_act", 32'(bus.voice_act_o), 32'hE);

        // Free voice reuse, then two steals confirming the age ordering.
        bus.sw = 8'h00;
        reset_pulse("reset2");
        push(0, 0, 1'b0);
        push(1, 1, 1'b0);
        push(2, 2, 1'b0);
        push(3, 3, 1'b0);
        bus.sw = 8'h0F;
        settle(9);
        bus.sw = 8'h0D;
        settle(5);
        check("free_release_act", 32'(bus.voice_act_o), 32'hD);
        push(1, 6, 1'b0);
        bus.sw = 8'h4D;
        settle(5);
        push(0, 7, 1'b1);
        bus.sw = 8'hCD;
        settle(5);
        push(2, 4, 1'b1);
        bus.sw = 8'hDD;
        settle(5);
        check("reuse_act", 32'(bus.voice_act_o), 32'hF);
        check("reuse_keys", 32'(bus.voice_key_o), 32'h737);
        drain("reuse_drain");

        // One-clock pulse on key 3 yields on then off; sub-cycle glitch yields nothing.
        bus.sw = 8'h00;
        reset_pulse("reset3");
        push(0, 3, 1'b0);
        bus.sw = 8'h08;
        tick();
        bus.sw = 8'h00;
        settle(6);
        check("pulse_act", 32'(bus.voice_act_o), 32'd0);
        drain("pulse_drain");
        busy_cnt = 0;
        @(posedge clk);
        #1 bus.sw = 8'h08;
        #2 bus.sw = 8'h00;
        settle(6);
        check("glitch_busy", 32'(busy_cnt), 32'd0);
        check("glitch_act", 32'(bus.voice_act_o), 32'd0);

        // Reset in the middle of an all-keys burst, then replay from scratch.
        push(0, 0, 1'b0);
        push(1, 1, 1'b0);
        bus.sw = 8'hFF;
        settle(4);
        drain("pre_reset_events");
        #2 rst = 1'b1;
        #1 check_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        steal_cnt = 0;
        for (int k = 0; k < 8; k++) push(k % 4, k, logic'(k >= 4));
        settle(14);
        check("replay_act", 32'(bus.voice_act_o), 32'hF);
        check("replay_keys", 32'(bus.voice_key_o), 32'hFAC);
        check("replay_steals", 32'(steal_cnt), 32'd4);
        drain("replay_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice allocator for the synthesizer audio path; replaces single-note key encoding with per-voice note assignment.
- Synchronizes the KEYS switch/key inputs and detects press/release events.
- Assigns pressed keys to VOICES tone-generator slots, stealing the oldest voice when all are busy.
- Per-voice key index, gate and retrigger pulse feed the downstream tone generators and envelopes.

Parameters:
KEYS, 8, number of key inputs; must be >= 2
VOICES, 4, number of voice slots; must be >= 2
KW, $clog2(KEYS), key index width (derived; not overridden)

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous, active-high reset
sw  input  KEYS  raw key levels, asynchronous to clk_i; 1 = pressed
voice_act_o  output  VOICES  gate per voice; 1 = voice holds a pressed key
voice_key_o  output  VOICES*KW  key index per voice; voice v occupies bits [v*KW +: KW]
voice_trig_o  output  VOICES  one-cycle pulse when voice v is (re)allocated
steal_o  output  1  one-cycle pulse when an allocation stole an active voice
busy_o  output  1  1 while unprocessed key changes remain

Behaviour:
- Reset (async, immediate) clears all of the following:
  - sync flops, acknowledged key state key_r, voice_act_o, voice_key_o, voice_trig_o, steal_o, busy_o.
  - Voice age set to age[v]=v.
- Synchronizer:
  - sw passes through a 2-flop synchronizer to give s.
  - pending = s ^ key_r.
  - busy_o = |pending, registered, so it lags pending by one cycle.
- Event selection:
  - Each cycle, if pending != 0, select the lowest set index k and process exactly one event.
  - key_r[k] <= s[k] on the same edge.
  - A key that toggles and returns before it is selected generates no event.
- Note-on (s[k]=1):
  - If any voice has act=0, allocate the lowest-index free voice a.
  - Otherwise allocate the voice with age==VOICES-1 and pulse steal_o.
  - On allocation: act[a]<=1, key[a]<=k, voice_trig_o[a] pulses for one cycle.
  - Age update on allocation: every voice with age<age[a] increments, age[a]<=0. Ages stay a permutation of 0..VOICES-1.
- Note-off (s[k]=0):
  - If a voice has act=1 and key==k, clear its act. key and age are unchanged.
  - If no voice matches (the note was stolen), no output change.
- At most one voice matches a key at any time.
  - A stolen key that is pressed again before its release has been processed is impossible, because key_r is tracked per key.
- Latency: a lone sw edge sampled at clock edge E0 reaches s after E1. Voice outputs and pulses update at E2, and pulses deassert at E3.
- Ordering: N simultaneous changes are processed over N consecutive cycles in ascending key index, regardless of press/release mix.
- Outputs are fully registered; there is no combinational path from sw.
- Reset asserted mid-sequence discards all pending events and voice state.
- After reset release, keys already held produce note-on events in ascending index order.

Test Plan:
- Reset, sw=0, then sw=8'h04 → two cycles later voice_act_o=4'b0001, voice 0 key=2, voice_trig_o=4'b0001 for 1 cycle, steal_o=0, busy_o 1 for one cycle.
- sw from 0 to 8'h0F in one cycle → over 4 consecutive cycles voices 0..3 get keys 0,1,2,3 in order; voice_act_o=4'hF; busy_o high 4 cycles.
- With keys 0..3 held, press key 5 → voice 0 (oldest) reassigned key 5, voice_trig_o=4'b0001, steal_o=1; later release key 0 → no output change; release key 5 → voice_act_o=4'b1110.
- Hold keys 0..3, release key 1, press key 6 → voice 1 (free) gets key 6, steal_o=0; ages still a permutation (check via a subsequent steal hitting voice 0).
- Pulse sw[3] high for a single clock only → either no event, or a note-on followed by a note-off with voice_act_o back to 0; no stuck voice; glitch held shorter than sampling → no trigger.
- Assert rst_i mid-burst (sw=8'hFF, after 2 events) → all outputs 0 immediately; after release with sw=8'hFF, 8 events processed, final voices hold keys 4..7 with 4 steal_o pulses.
